// File: rtl/control_sequencer.sv
// Moore control sequencer for the bus-based CPU datapath: instruction fetch,
// per-opcode T-step strobes, memory wait stretching, pause and halt handling.
module control_sequencer #(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] ir_opcode,
    input  logic       con_ff,
    input  logic       stop,
    output logic       run,
    output logic       illegal_op,
    output logic [3:0] step,
    output logic       PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, ramWE, IRin,
    output logic       Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, HIout, LOin, LOout,
    output logic       Gra, Grb, Grc, R_in, R_out, BAout, Cout, CONin, InPortout, OutPortIn,
    output logic       link_in
);

    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
        S_WAIT = 4'd8, S_PAUSE = 4'd9, S_HALT = 4'd10, S_RESET = 4'd15
    } state_t;

    localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2;
    localparam logic [4:0] OP_MUL = 5'd15, OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18;
    localparam logic [4:0] OP_BR = 5'd19, OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22;
    localparam logic [4:0] OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP = 5'd26, OP_HALT = 5'd27;
    localparam logic [1:0] WAIT_LOAD = (MEM_WAIT > 0) ? 2'(MEM_WAIT - 1) : 2'd0;

    state_t     r_state, w_next, w_adv;
    logic [1:0] r_wait_cnt;
    logic [2:0] r_wait_step;
    logic [2:0] w_step;
    logic       w_active, w_last;

    function automatic logic [2:0] last_step(input logic [4:0] op);
        if (op == OP_LD || op == OP_ST)                 return 3'd7;
        else if (op == OP_LDI || (op >= 5'd3 && op <= 5'd14)) return 3'd5;
        else if (op == OP_MUL || op == OP_DIV || op == OP_BR) return 3'd6;
        else if (op == OP_NEG || op == OP_NOT || op == OP_JAL) return 3'd4;
        else                                            return 3'd3;
    endfunction

    // Steps that touch RAM and get stretched by the wait counter.
    function automatic logic needs_wait(input logic [2:0] t, input logic [4:0] op);
        return (t == 3'd1) || (t == 3'd6 && op == OP_LD) || (t == 3'd7 && op == OP_ST);
    endfunction

    // While waiting, everything decodes as the step that owns the wait.
    assign w_step   = (r_state == S_WAIT) ? r_wait_step : r_state[2:0];
    assign w_active = (r_state != S_RESET) && (r_state != S_PAUSE) && (r_state != S_HALT);
    assign w_last   = (w_step == last_step(ir_opcode));
    assign w_adv    = w_last ? (stop ? S_PAUSE : S_T0) : state_t'({1'b0, w_step + 3'd1});

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= S_RESET;
            r_wait_cnt  <= 2'd0;
            r_wait_step <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_next == S_WAIT && r_state != S_WAIT) begin
                r_wait_cnt  <= WAIT_LOAD;
                r_wait_step <= r_state[2:0];
            end else if (r_state == S_WAIT && r_wait_cnt != 2'd0) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: w_next = S_T0;
            S_HALT:  w_next = S_HALT;
            S_PAUSE: if (!stop) w_next = S_T0;
            S_WAIT:  if (r_wait_cnt == 2'd0) w_next = w_adv;
            S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (r_state == S_T3 && ir_opcode == OP_HALT)
                    w_next = S_HALT;
                else if (MEM_WAIT > 0 && needs_wait(r_state[2:0], ir_opcode))
                    w_next = S_WAIT;
                else
                    w_next = w_adv;
            end
            default: w_next = S_RESET;
        endcase
    end

    always_comb begin
        {PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, ramWE, IRin, Yin} = '0;
        {ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, HIout, LOin, LOout} = '0;
        {Gra, Grb, Grc, R_in, R_out, BAout, Cout, CONin, InPortout, OutPortIn, link_in} = '0;
        illegal_op = 1'b0;
        run        = w_active;
        step       = w_active ? {1'b0, w_step} : 4'hF;
        if (w_active) begin
            case (w_step)
                3'd0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
                3'd1: begin Read = 1'b1; MDRin = 1'b1; end
                3'd2: begin MDRout = 1'b1; IRin = 1'b1; end
                default: begin
                    case (ir_opcode) inside
                        OP_LD, OP_LDI, OP_ST: case (w_step)
                            3'd3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                            3'd4: begin Cout = 1'b1; ZLowIn = 1'b1; end
                            3'd5: if (ir_opcode == OP_LDI) begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                                  else begin ZLowout = 1'b1; MARin = 1'b1; end
                            3'd6: if (ir_opcode == OP_LD) begin Read = 1'b1; MDRin = 1'b1; end
                                  else if (ir_opcode == OP_ST) begin Gra = 1'b1; R_out = 1'b1; MDRin = 1'b1; end
                            3'd7: if (ir_opcode == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                                  else if (ir_opcode == OP_ST) ramWE = 1'b1;
                            default: ;
                        endcase
                        [5'd3:5'd14]: case (w_step)
                            3'd3: begin Grb = 1'b1; R_out = 1'b1; Yin = 1'b1; end
                            3'd4: if (ir_opcode <= 5'd11) begin Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; end
                                  else begin Cout = 1'b1; ZLowIn = 1'b1; end
                            3'd5: begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                            default: ;
                        endcase
                        OP_MUL, OP_DIV: case (w_step)
                            3'd3: begin Gra = 1'b1; R_out = 1'b1; Yin = 1'b1; end
                            3'd4: begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; end
                            3'd5: begin ZLowout = 1'b1; LOin = 1'b1; end
                            3'd6: begin ZHighout = 1'b1; HIin = 1'b1; end
                            default: ;
                        endcase
                        OP_NEG, OP_NOT: case (w_step)
                            3'd3: begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; end
                            3'd4: begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                            default: ;
                        endcase
                        OP_BR: case (w_step)
                            3'd3: begin Gra = 1'b1; R_out = 1'b1; CONin = 1'b1; end
                            3'd4: begin PCout = 1'b1; Yin = 1'b1; end
                            3'd5: begin Cout = 1'b1; ZLowIn = 1'b1; end
                            3'd6: if (con_ff) begin ZLowout = 1'b1; PCin = 1'b1; end
                            default: ;
                        endcase
                        OP_JR:   if (w_step == 3'd3) begin Gra = 1'b1; R_out = 1'b1; PCin = 1'b1; end
                        OP_JAL:  if (w_step == 3'd3) begin PCout = 1'b1; link_in = 1'b1; end
                                 else if (w_step == 3'd4) begin Gra = 1'b1; R_out = 1'b1; PCin = 1'b1; end
                        OP_IN:   if (w_step == 3'd3) begin InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                        OP_OUT:  if (w_step == 3'd3) begin Gra = 1'b1; R_out = 1'b1; OutPortIn = 1'b1; end
                        OP_MFHI: if (w_step == 3'd3) begin HIout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                        OP_MFLO: if (w_step == 3'd3) begin LOout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                        OP_NOP, OP_HALT: ;
                        default: if (w_step == 3'd3) illegal_op = 1'b1;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: table of per-opcode step sequences
// plus hand-written reset, wait, pause and halt scenarios.
module tb_control_sequencer;

    localparam logic [29:0] PCOUT = 30'd1 << 0, INCPC = 30'd1 << 1, PCIN = 30'd1 << 2;
    localparam logic [29:0] MARIN = 30'd1 << 3, MDRIN = 30'd1 << 4, MDROUT = 30'd1 << 5;
    localparam logic [29:0] READ = 30'd1 << 6, RAMWE = 30'd1 << 7, IRIN = 30'd1 << 8;
    localparam logic [29:0] YIN = 30'd1 << 9, ZLIN = 30'd1 << 10, ZHIN = 30'd1 << 11;
    localparam logic [29:0] ZLOUT = 30'd1 << 12, ZHOUT = 30'd1 << 13, HIIN = 30'd1 << 14;
    localparam logic [29:0] HIOUT = 30'd1 << 15, LOIN = 30'd1 << 16, LOOUT = 30'd1 << 17;
    localparam logic [29:0] GRA = 30'd1 << 18, GRB = 30'd1 << 19, GRC = 30'd1 << 20;
    localparam logic [29:0] RIN = 30'd1 << 21, ROUT = 30'd1 << 22, BAOUT = 30'd1 << 23;
    localparam logic [29:0] COUT = 30'd1 << 24, CONIN = 30'd1 << 25, INPOUT = 30'd1 << 26;
    localparam logic [29:0] OUTPIN = 30'd1 << 27, LINK = 30'd1 << 28, ILL = 30'd1 << 29;

    typedef struct {
        logic [4:0]       op;
        logic             con;
        int               n;
        logic [5:0][30:0] exp;
        logic [5:0][3:0]  stp;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       con = 1'b0;
    logic       stop = 1'b0;
    logic [4:0] op = 5'd0;

    wire [1:0][28:0] sb;
    wire [1:0]       run_o, ill_o;
    wire [1:0][3:0]  step_o;

    int   total = 0;
    int   bad = 0;
    vec_t vt[24];
    int   nv = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_sequencer #(.MEM_WAIT(g + 1)) u_dut (
            .clk(clk), .clr(clr), .ir_opcode(op), .con_ff(con), .stop(stop),
            .run(run_o[g]), .illegal_op(ill_o[g]), .step(step_o[g]),
            .PCout(sb[g][0]), .IncPC(sb[g][1]), .PCin(sb[g][2]), .MARin(sb[g][3]),
            .MDRin(sb[g][4]), .MDRout(sb[g][5]), .Read(sb[g][6]), .ramWE(sb[g][7]),
            .IRin(sb[g][8]), .Yin(sb[g][9]), .ZLowIn(sb[g][10]), .ZHighIn(sb[g][11]),
            .ZLowout(sb[g][12]), .ZHighout(sb[g][13]), .HIin(sb[g][14]), .HIout(sb[g][15]),
            .LOin(sb[g][16]), .LOout(sb[g][17]), .Gra(sb[g][18]), .Grb(sb[g][19]),
            .Grc(sb[g][20]), .R_in(sb[g][21]), .R_out(sb[g][22]), .BAout(sb[g][23]),
            .Cout(sb[g][24]), .CONin(sb[g][25]), .InPortout(sb[g][26]),
            .OutPortIn(sb[g][27]), .link_in(sb[g][28])
        );
    end

    function automatic logic [30:0] obs(input int i);
        return {run_o[i], ill_o[i], sb[i]};
    endfunction

    function automatic logic [30:0] ex(input logic [29:0] v);
        return {1'b1, v};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [30:0] got, input logic [30:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic chk_at(input string nm, input int i, input logic [29:0] v, input int s);
        chk({nm, "_strobes"}, obs(i), (s == 15) ? 31'd0 : ex(v));
        chk({nm, "_step"}, 31'(step_o[i]), 31'(s));
    endtask

    task automatic start(input logic [4:0] o, input logic c);
        clr = 1'b1; op = o; con = c; stop = 1'b0;
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic fetch(input int i, input int mw);
        chk_at("fetch_t0", i, PCOUT | MARIN | INCPC, 0);
        tick();
        for (int k = 0; k <= mw; k++) begin
            chk_at("fetch_t1", i, READ | MDRIN, 1);
            tick();
        end
        chk_at("fetch_t2", i, MDROUT | IRIN, 2);
        tick();
    endtask

    task automatic add_v(input logic [4:0] o, input logic c, input int n,
                         input logic [29:0] e0, input logic [29:0] e1, input logic [29:0] e2,
                         input logic [29:0] e3, input logic [29:0] e4, input logic [29:0] e5);
        vt[nv].op = o; vt[nv].con = c; vt[nv].n = n;
        vt[nv].exp[0] = ex(e0); vt[nv].exp[1] = ex(e1); vt[nv].exp[2] = ex(e2);
        vt[nv].exp[3] = ex(e3); vt[nv].exp[4] = ex(e4); vt[nv].exp[5] = ex(e5);
        for (int k = 0; k < 6; k++) vt[nv].stp[k] = 4'(3 + k);
        nv++;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [29:0] se[13];
        int          ss[13];
        int          nwe, nrd;

        add_v(5'd3,  1'b0, 3, GRB | ROUT | YIN, GRC | ROUT | ZLIN, ZLOUT | GRA | RIN, 0, 0, 0);
        add_v(5'd11, 1'b0, 3, GRB | ROUT | YIN, GRC | ROUT | ZLIN, ZLOUT | GRA | RIN, 0, 0, 0);
        add_v(5'd1,  1'b0, 3, GRB | BAOUT | YIN, COUT | ZLIN, ZLOUT | GRA | RIN, 0, 0, 0);
        add_v(5'd0,  1'b0, 6, GRB | BAOUT | YIN, COUT | ZLIN, ZLOUT | MARIN,
              READ | MDRIN, READ | MDRIN, MDROUT | GRA | RIN);
        vt[nv - 1].stp[4] = 4'd6; vt[nv - 1].stp[5] = 4'd7;
        add_v(5'd12, 1'b0, 3, GRB | ROUT | YIN, COUT | ZLIN, ZLOUT | GRA | RIN, 0, 0, 0);
        add_v(5'd14, 1'b0, 3, GRB | ROUT | YIN, COUT | ZLIN, ZLOUT | GRA | RIN, 0, 0, 0);
        add_v(5'd16, 1'b0, 4, GRA | ROUT | YIN, GRB | ROUT | ZLIN | ZHIN, ZLOUT | LOIN, ZHOUT | HIIN, 0, 0);
        add_v(5'd17, 1'b0, 2, GRB | ROUT | ZLIN, ZLOUT | GRA | RIN, 0, 0, 0, 0);
        add_v(5'd18, 1'b0, 2, GRB | ROUT | ZLIN, ZLOUT | GRA | RIN, 0, 0, 0, 0);
        add_v(5'd19, 1'b0, 4, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZLIN, 0, 0, 0);
        add_v(5'd19, 1'b1, 4, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZLIN, ZLOUT | PCIN, 0, 0);
        add_v(5'd20, 1'b0, 1, GRA | ROUT | PCIN, 0, 0, 0, 0, 0);
        add_v(5'd21, 1'b0, 2, PCOUT | LINK, GRA | ROUT | PCIN, 0, 0, 0, 0);
        add_v(5'd22, 1'b1, 1, INPOUT | GRA | RIN, 0, 0, 0, 0, 0);
        add_v(5'd23, 1'b0, 1, GRA | ROUT | OUTPIN, 0, 0, 0, 0, 0);
        add_v(5'd24, 1'b0, 1, HIOUT | GRA | RIN, 0, 0, 0, 0, 0);
        add_v(5'd25, 1'b0, 1, LOOUT | GRA | RIN, 0, 0, 0, 0, 0);
        add_v(5'd26, 1'b1, 1, 0, 0, 0, 0, 0, 0);
        add_v(5'd29, 1'b0, 1, ILL, 0, 0, 0, 0, 0);
        add_v(5'd31, 1'b1, 1, ILL, 0, 0, 0, 0, 0);

        tick(); tick();
        chk_at("reset_w1", 0, 0, 15);
        chk_at("reset_w2", 1, 0, 15);

        // Table: MEM_WAIT=1 instance, fetch + execute + return to T0
        for (int v = 0; v < nv; v++) begin
            start(vt[v].op, vt[v].con);
            fetch(0, 1);
            for (int k = 0; k < vt[v].n; k++) begin
                chk($sformatf("op%0d_c%0d_x%0d_strobes", vt[v].op, vt[v].con, k), obs(0), vt[v].exp[k]);
                chk($sformatf("op%0d_c%0d_x%0d_step", vt[v].op, vt[v].con, k),
                    31'(step_o[0]), 31'(vt[v].stp[k]));
                tick();
            end
            chk_at($sformatf("op%0d_c%0d_back_t0", vt[v].op, vt[v].con), 0, PCOUT | MARIN | INCPC, 0);
        end

        // clr held three cycles while ld sits at T6
        start(5'd0, 1'b0);
        fetch(0, 1);
        tick(); tick(); tick();
        chk_at("ld_at_t6", 0, READ | MDRIN, 6);
        clr = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk_at("abort_reset", 0, 0, 15);
        end
        clr = 1'b0;
        tick();
        chk_at("abort_release_t0", 0, PCOUT | MARIN | INCPC, 0);

        // st on the MEM_WAIT=2 instance
        se = '{PCOUT | MARIN | INCPC, READ | MDRIN, READ | MDRIN, READ | MDRIN, MDROUT | IRIN,
               GRB | BAOUT | YIN, COUT | ZLIN, ZLOUT | MARIN, GRA | ROUT | MDRIN,
               RAMWE, RAMWE, RAMWE, PCOUT | MARIN | INCPC};
        ss = '{0, 1, 1, 1, 2, 3, 4, 5, 6, 7, 7, 7, 0};
        nwe = 0; nrd = 0;
        start(5'd2, 1'b0);
        for (int k = 0; k < 13; k++) begin
            chk_at($sformatf("st_w2_c%0d", k), 1, se[k], ss[k]);
            if (k < 12) nwe += int'(sb[1][7]);
            if (k >= 5 && k < 12) nrd += int'(sb[1][6]);
            tick();
        end
        chk("st_w2_ramwe_cycles", 31'(nwe), 31'd3);
        chk("st_w2_read_in_exec", 31'(nrd), 31'd0);

        // stop raised at T4 of mul: finishes, pauses, resumes
        start(5'd15, 1'b0);
        fetch(0, 1);
        chk_at("mul_t3", 0, GRA | ROUT | YIN, 3);
        tick();
        chk_at("mul_t4", 0, GRB | ROUT | ZLIN | ZHIN, 4);
        stop = 1'b1;
        tick();
        chk_at("mul_t5", 0, ZLOUT | LOIN, 5);
        tick();
        chk_at("mul_t6", 0, ZHOUT | HIIN, 6);
        tick();
        chk_at("pause_1", 0, 0, 15);
        tick();
        chk_at("pause_2", 0, 0, 15);
        stop = 1'b0;
        tick();
        chk_at("resume_t0", 0, PCOUT | MARIN | INCPC, 0);

        // halt held until clr
        start(5'd27, 1'b0);
        fetch(0, 1);
        chk_at("halt_t3", 0, 0, 3);
        for (int r = 0; r < 20; r++) begin
            tick();
            chk_at($sformatf("halt_hold_%0d", r), 0, 0, 15);
        end
        clr = 1'b1;
        tick();
        chk_at("halt_clr", 0, 0, 15);
        clr = 1'b0;
        tick();
        chk_at("halt_release_t0", 0, PCOUT | MARIN | INCPC, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
